sprite_pixel_pipe: RTL and testbench
====================================

// Module: sprite_pixel_pipe
// PURPOSE
//  Downstream consumer of the sprite frame RAM (3-bit palette index per texel, 20x20 sprite, 1-cycle read latency).
//  Per VGA pixel: tests whether DrawX/DrawY lies inside the sprite, drives the RAM read address, absorbs the RAM latency.
//  Converts the returned index to 24-bit RGB plus a hit flag for the colour mux downstream.
//  Sprite position/enable are double-buffered and committed only at frame start, so no tearing.
// PARAMETERS
//  SPR_W      20    sprite width in texels
//  SPR_H      20    sprite height in texels
//  BASE_ADDR  0     RAM word address of texel (0,0)
//  ADDR_W     19    RAM address width
//  H_ACTIVE   640   visible columns
//  V_ACTIVE   480   visible rows
// PORTS
//  Clk           in   1       system clock
//  Reset         in   1       synchronous, active-low reset
//  DrawX         in   10      current pixel column
//  DrawY         in   10      current pixel row
//  pix_valid_in  in   1       1 = visible pixel this cycle
//  frame_start   in   1       1-cycle pulse, start of vertical blank
//  SpriteX       in   10      requested sprite left column (shadowed)
//  SpriteY       in   10      requested sprite top row (shadowed)
//  sprite_en     in   1       requested visibility (shadowed)
//  rd_address    out  ADDR_W  read address to frame RAM (registered)
//  ram_data      in   3       palette index from RAM, valid 1 cycle after rd_address
//  pix_valid_out out  1       pix_valid_in delayed 3 cycles
//  sprite_hit    out  1       opaque sprite texel at this output pixel
//  Red           out  8       colour channels; 0 when sprite_hit=0
//  Green         out  8       colour channels; 0 when sprite_hit=0
//  Blue          out  8       colour channels; 0 when sprite_hit=0
// BEHAVIOUR
//  Reset (Reset==0 at posedge):
//   - All outputs 0; rd_address=BASE_ADDR.
//   - Shadow regs cleared (en=0); pipeline valid/hit bits cleared; FSM -> WAIT_FRAME.
//  FSM:
//   - WAIT_FRAME: hits suppressed. frame_start -> ACTIVE.
//   - ACTIVE: stays until reset.
//  Shadow: on frame_start, sx<=SpriteX, sy<=SpriteY, sen<=sprite_en; held otherwise.
//   - The compare uses the new values from the cycle after the pulse.
//  S1 (t+1):
//   - in = pix_valid_in & sen & ACTIVE & DrawX in [sx, sx+SPR_W-1] & DrawY in [sy, sy+SPR_H-1].
//   - Range compares done in 11 bits, so sx+SPR_W past H_ACTIVE does not wrap; off-screen texels are simply never drawn.
//   - col=DrawX-sx, row=DrawY-sy (5 bits each); rd_address <= BASE_ADDR + row*SPR_W + col.
//   - rd_address is updated only when in=1, else it holds its value.
//  S2 (t+2): ram_data valid; carry in and pix_valid stage bits.
//  S3 (t+3):
//   - sprite_hit <= in & (ram_data!=0); index 0 is transparent.
//   - RGB <= palette[ram_data] if hit, else 0.
//  Latency: fixed 3 cycles for every pixel, hit or not; no stalls, no backpressure.
//  Mid-frame reset: pipeline flushed; no hit until the next frame_start.
//  frame_start coincident with pix_valid_in=1: that cycle compares against the old shadow values.
// CONFIGURATION
//  SPRITE_MIRROR_EN defined:
//   - Extra inputs flip_h, flip_v (1b each), shadowed with position.
//   - col' = SPR_W-1-col when flip_h; row' = SPR_H-1-row when flip_v.
//   - Latency unchanged.
//  Undefined: ports absent; col/row used directly.
// STRUCTURE
//  Package tank_gfx_pkg:
//   - SPR_W/SPR_H defaults; typedef rgb_t (struct of 3x8b); typedef pal_idx_t (logic [2:0]).
//   - Constant PALETTE[8] of rgb_t.
//  Sub-module sprite_palette: registered pal_idx_t -> rgb_t lookup; implements S3 colour.
// TESTING
//  1. Reset low 2 cycles, then high -> all outputs 0.
//     Pixels in the sprite area before any frame_start -> sprite_hit=0.
//  2. frame_start with SpriteX=100, SpriteY=50, en=1; DrawX=105, DrawY=53 -> rd_address=65 (BASE 0) at t+1.
//     RAM returns 3 -> sprite_hit=1, RGB=PALETTE[3] at t+3.
//  3. Same pixel with RAM returning 0 -> sprite_hit=0, RGB=0, pix_valid_out=1 at t+3.
//  4. SpriteX=630: DrawX=639 hits (addr col 9); DrawX=0 with row in range -> no hit (no wrap).
//  5. Change SpriteX mid-frame -> no effect until the next frame_start.
//     Reset asserted mid-line -> sprite_hit=0 from the next cycle.
//  6. SPRITE_MIRROR_EN, flip_h=1, col 0 requested -> rd_address col=19.

Source files
------------

// File: rtl/tank_gfx_pkg.sv
// Shared sprite graphics types: palette index, RGB triple, fixed palette.
// Also holds the sprite FSM state encoding.
package tank_gfx_pkg;

  localparam int SPR_W_DEF = 20;
  localparam int SPR_H_DEF = 20;

  typedef logic [2:0] pal_idx_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    WAIT_FRAME,
    ACTIVE
  } spr_state_e;

  // Index 0 is transparent, so its colour is never shown.
  localparam rgb_t PALETTE [8] = '{
    '{8'h00, 8'h00, 8'h00},
    '{8'hFF, 8'hFF, 8'hFF},
    '{8'hC8, 8'h32, 8'h14},
    '{8'h28, 8'h50, 8'hA0},
    '{8'hF0, 8'hD0, 8'h20},
    '{8'h30, 8'hA0, 8'h40},
    '{8'h80, 8'h80, 8'h80},
    '{8'h60, 8'h30, 8'h10}
  };

endpackage

// File: rtl/sprite_palette.sv
// Registered palette lookup for the final pipeline stage.
// Output is black whenever the texel is not drawn.
module sprite_palette
  import tank_gfx_pkg::*;
(
  input  logic     Clk,
  input  logic     Reset,
  input  logic     en_i,
  input  pal_idx_t idx_i,
  output rgb_t     rgb_o
);

  rgb_t rgb_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rgb_q <= '0;
    end else if (en_i) begin
      rgb_q <= PALETTE[idx_i];
    end else begin
      rgb_q <= '0;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Sprite hit test, frame RAM addressing and colour output, 3-cycle latency.
// Define SPRITE_MIRROR_EN for flip_h/flip_v texel mirroring.
module sprite_pixel_pipe
  import tank_gfx_pkg::*;
#(
  parameter int SPR_W     = SPR_W_DEF,
  parameter int SPR_H     = SPR_H_DEF,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 19,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid_in,
  input  logic              frame_start,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic              sprite_en,
`ifdef SPRITE_MIRROR_EN
  input  logic              flip_h,
  input  logic              flip_v,
`endif
  output logic [ADDR_W-1:0] rd_address,
  input  logic [2:0]        ram_data,
  output logic              pix_valid_out,
  output logic              sprite_hit,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  spr_state_e state_q, state_d;

  logic [9:0] sx_q, sy_q;
  logic       sen_q;
  logic       fh_q, fv_q;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in1_q, v1_q;
  logic              in2_q, v2_q;
  logic              hit_q, v3_q;
  logic              hit_d;

  logic [10:0] x11, y11, sx11, sy11;
  logic        x_in, y_in, pix_in;
  logic [CW-1:0] col, col_m;
  logic [RW-1:0] row, row_m;
  rgb_t          rgb;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= WAIT_FRAME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_FRAME: if (frame_start) state_d = ACTIVE;
      ACTIVE:     state_d = ACTIVE;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // Shadow copies only move at frame start so a frame never tears.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sx_q  <= '0;
      sy_q  <= '0;
      sen_q <= 1'b0;
      fh_q  <= 1'b0;
      fv_q  <= 1'b0;
    end else if (frame_start) begin
      sx_q  <= SpriteX;
      sy_q  <= SpriteY;
      sen_q <= sprite_en;
`ifdef SPRITE_MIRROR_EN
      fh_q  <= flip_h;
      fv_q  <= flip_v;
`else
      fh_q  <= 1'b0;
      fv_q  <= 1'b0;
`endif
    end
  end

  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign sx11 = {1'b0, sx_q};
  assign sy11 = {1'b0, sy_q};

  assign x_in = (x11 >= sx11)
             && (x11 <= sx11 + 11'(SPR_W - 1))
             && (x11 < 11'(H_ACTIVE));
  assign y_in = (y11 >= sy11)
             && (y11 <= sy11 + 11'(SPR_H - 1))
             && (y11 < 11'(V_ACTIVE));

  assign pix_in = pix_valid_in & sen_q
                & (state_q == ACTIVE)
                & x_in & y_in;

  assign col   = CW'(DrawX - sx_q);
  assign row   = RW'(DrawY - sy_q);
  assign col_m = fh_q ? CW'(SPR_W - 1) - col : col;
  assign row_m = fv_q ? RW'(SPR_H - 1) - row : row;

  always_comb begin
    addr_d = addr_q;
    if (pix_in) begin
      addr_d = ADDR_W'(BASE_ADDR)
             + ADDR_W'(row_m) * ADDR_W'(SPR_W)
             + ADDR_W'(col_m);
    end
  end

  assign hit_d = in2_q & (ram_data != 3'd0);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      addr_q <= ADDR_W'(BASE_ADDR);
      in1_q  <= 1'b0;
      v1_q   <= 1'b0;
      in2_q  <= 1'b0;
      v2_q   <= 1'b0;
      hit_q  <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      in1_q  <= pix_in;
      v1_q   <= pix_valid_in;
      in2_q  <= in1_q;
      v2_q   <= v1_q;
      hit_q  <= hit_d;
      v3_q   <= v2_q;
    end
  end

  sprite_palette u_pal (
    .Clk   (Clk),
    .Reset (Reset),
    .en_i  (hit_d),
    .idx_i (ram_data),
    .rgb_o (rgb)
  );

  assign rd_address    = addr_q;
  assign pix_valid_out = v3_q;
  assign sprite_hit    = hit_q;
  assign Red           = rgb.r;
  assign Green         = rgb.g;
  assign Blue          = rgb.b;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Bench for sprite_pixel_pipe: vector table plus scoreboard queue.
// Mirror vectors run only when SPRITE_MIRROR_EN is defined.
module tb_sprite_pixel_pipe;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        pix_valid_in, frame_start;
  logic [9:0]  SpriteX, SpriteY;
  logic        sprite_en;
  logic        flip_h, flip_v;
  logic [18:0] rd_address;
  logic [2:0]  ram_data;
  logic        pix_valid_out, sprite_hit;
  logic [7:0]  Red, Green, Blue;

  always #5 Clk = ~Clk;

  sprite_pixel_pipe dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .pix_valid_in  (pix_valid_in),
    .frame_start   (frame_start),
    .SpriteX       (SpriteX),
    .SpriteY       (SpriteY),
    .sprite_en     (sprite_en),
`ifdef SPRITE_MIRROR_EN
    .flip_h        (flip_h),
    .flip_v        (flip_v),
`endif
    .rd_address    (rd_address),
    .ram_data      (ram_data),
    .pix_valid_out (pix_valid_out),
    .sprite_hit    (sprite_hit),
    .Red           (Red),
    .Green         (Green),
    .Blue          (Blue)
  );

  logic [2:0] mem [512];

  always @(posedge Clk) begin
    if (rd_address < 19'd512) ram_data <= mem[rd_address[8:0]];
    else                      ram_data <= 3'd0;
  end

  logic [23:0] pal_exp [8];

  typedef struct packed {
    logic        rst, fs, pv;
    logic [9:0]  dx, dy, spx, spy;
    logic        en, fh, fv;
    logic        ev, eh;
    logic [2:0]  ei;
    logic [18:0] ea;
  } vec_t;

  typedef struct packed {
    logic       v, h;
    logic [2:0] i;
  } exp_t;

  exp_t        sb [$];
  logic [18:0] addr_exp;
  logic        addr_armed = 1'b0;
  int          total = 0;
  int          bad = 0;
  vec_t        tbl [24];

  function automatic vec_t mk(
    input logic rst, fs, pv,
    input int dx, dy, spx, spy,
    input logic en, ev, eh,
    input int ei, ea);
    vec_t v;
    v.rst = rst; v.fs = fs; v.pv = pv;
    v.dx = 10'(dx); v.dy = 10'(dy);
    v.spx = 10'(spx); v.spy = 10'(spy);
    v.en = en; v.fh = 1'b0; v.fv = 1'b0;
    v.ev = ev; v.eh = eh;
    v.ei = 3'(ei); v.ea = 19'(ea);
    return v;
  endfunction

  function automatic vec_t idle(input int ea);
    return mk(1, 0, 0, 0, 0, 100, 50, 1, 0, 0, 0, ea);
  endfunction

  task automatic cmp(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(negedge Clk);
    if (sb.size() == 3) begin
      e = sb.pop_front();
      cmp("valid", 32'(pix_valid_out), 32'(e.v));
      cmp("hit", 32'(sprite_hit), 32'(e.h));
      cmp("rgb", 32'({Red, Green, Blue}),
          e.h ? 32'(pal_exp[e.i]) : 32'd0);
    end
    if (addr_armed) cmp("rd_address", 32'(rd_address), 32'(addr_exp));
    Reset        = v.rst;
    frame_start  = v.fs;
    pix_valid_in = v.pv;
    DrawX        = v.dx;
    DrawY        = v.dy;
    SpriteX      = v.spx;
    SpriteY      = v.spy;
    sprite_en    = v.en;
    flip_h       = v.fh;
    flip_v       = v.fv;
    if (!v.rst) begin
      foreach (sb[k]) sb[k] = '0;
    end
    e.v = v.ev; e.h = v.eh; e.i = v.ei;
    sb.push_back(e);
    addr_exp   = v.ea;
    addr_armed = 1'b1;
  endtask

  initial begin
    vec_t v;
    pal_exp = '{24'h000000, 24'hFFFFFF, 24'hC83214, 24'h2850A0,
                24'hF0D020, 24'h30A040, 24'h808080, 24'h603010};
    foreach (mem[k]) mem[k] = 3'd0;
    mem[65] = 3'd3;  mem[399] = 3'd7; mem[1]   = 3'd1;
    mem[9]  = 3'd5;  mem[389] = 3'd2; mem[19]  = 3'd4;
    mem[378] = 3'd6;
    Reset = 1'b0; frame_start = 1'b0; pix_valid_in = 1'b0;
    DrawX = '0; DrawY = '0; SpriteX = '0; SpriteY = '0;
    sprite_en = 1'b0; flip_h = 1'b0; flip_v = 1'b0;

    //            rst fs pv  dx   dy  spx  spy en ev eh ei  ea
    tbl[0]  = mk(0, 0, 0,   0,   0, 100,  50, 1, 0, 0, 0,   0);
    tbl[1]  = mk(0, 0, 0,   0,   0, 100,  50, 1, 0, 0, 0,   0);
    tbl[2]  = mk(1, 0, 1, 105,  53, 100,  50, 1, 1, 0, 0,   0);
    tbl[3]  = mk(1, 0, 1, 105,  53, 100,  50, 1, 1, 0, 0,   0);
    tbl[4]  = mk(1, 1, 1, 105,  53, 100,  50, 1, 1, 0, 0,   0);
    tbl[5]  = mk(1, 0, 1, 105,  53, 100,  50, 1, 1, 1, 3,  65);
    tbl[6]  = mk(1, 0, 0, 105,  53, 100,  50, 1, 0, 0, 0,  65);
    tbl[7]  = mk(1, 0, 1,  99,  53, 100,  50, 1, 1, 0, 0,  65);
    tbl[8]  = mk(1, 0, 1, 119,  69, 100,  50, 1, 1, 1, 7, 399);
    tbl[9]  = mk(1, 0, 1, 120,  69, 100,  50, 1, 1, 0, 0, 399);
    tbl[10] = mk(1, 0, 1, 100,  50, 100,  50, 1, 1, 0, 0,   0);
    tbl[11] = mk(1, 0, 1, 101,  50, 100,  50, 1, 1, 1, 1,   1);
    tbl[12] = mk(1, 0, 1, 105,  53, 300,  50, 1, 1, 1, 3,  65);
    tbl[13] = mk(1, 1, 1, 105,  53, 630, 100, 1, 1, 1, 3,  65);
    tbl[14] = mk(1, 0, 1, 639, 100, 630, 100, 1, 1, 1, 5,   9);
    tbl[15] = mk(1, 0, 1,   0, 100, 630, 100, 1, 1, 0, 0,   9);
    tbl[16] = mk(1, 0, 1, 639, 119, 630, 100, 1, 1, 1, 2, 389);
    tbl[17] = mk(1, 0, 1, 630, 120, 630, 100, 1, 1, 0, 0, 389);
    tbl[18] = mk(1, 1, 1, 630, 100, 630, 100, 0, 1, 0, 0,   0);
    tbl[19] = mk(1, 0, 1, 630, 100, 630, 100, 0, 1, 0, 0,   0);
    tbl[20] = mk(1, 1, 0, 105,  53, 100,  50, 1, 0, 0, 0,   0);
    tbl[21] = mk(1, 0, 1, 105,  53, 100,  50, 1, 1, 1, 3,  65);
    tbl[22] = mk(0, 0, 1, 105,  53, 100,  50, 1, 0, 0, 0,   0);
    tbl[23] = mk(1, 0, 1, 105,  53, 100,  50, 1, 1, 0, 0,   0);

    for (int i = 0; i < 24; i++) step(tbl[i]);

    // Transparent texel at a hitting position.
    step(mk(1, 1, 0, 0, 0, 100, 50, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(idle(0));
    mem[65] = 3'd0;
    step(mk(1, 0, 1, 105, 53, 100, 50, 1, 1, 0, 0, 65));
    for (int i = 0; i < 3; i++) step(idle(65));

`ifdef SPRITE_MIRROR_EN
    v = mk(1, 1, 0, 0, 0, 100, 50, 1, 0, 0, 0, 65);
    v.fh = 1'b1;
    step(v);
    step(mk(1, 0, 1, 100, 50, 100, 50, 1, 1, 1, 4, 19));
    v = mk(1, 1, 0, 0, 0, 100, 50, 1, 0, 0, 0, 19);
    v.fh = 1'b1; v.fv = 1'b1;
    step(v);
    step(mk(1, 0, 1, 101, 51, 100, 50, 1, 1, 1, 6, 378));
    for (int i = 0; i < 3; i++) step(idle(378));
`else
    v = idle(65);
    step(v);
`endif

    for (int i = 0; i < 4; i++) step(idle(addr_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
